// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models mult/div latency, requests D-stage stall.
// Optional divider: define MD_DIV_EN to build div/divu; otherwise md_op 3/4 are no-ops.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = ($clog2(MAXC) > 4) ? $clog2(MAXC) : 4;

`ifdef MD_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;
`else
  typedef enum logic {S_IDLE, S_MULT} state_t;
`endif

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q, b_q;
  logic          sgn_q;

  logic          is_mul, is_div, start_mul, start_div, start_any, commit;
  logic [CW-1:0] cnt_load;
  logic [31:0]   res_hi, res_lo;
  logic          res_ok;
  logic [63:0]   ext_a, ext_b, product;

  assign busy = (state != S_IDLE);

  always_comb begin
    is_mul = (md_op == 3'd1) || (md_op == 3'd2);
`ifdef MD_DIV_EN
    is_div = (md_op == 3'd3) || (md_op == 3'd4);
`else
    is_div = 1'b0;
`endif
    start_mul = (state == S_IDLE) && !flush && is_mul;
    start_div = (state == S_IDLE) && !flush && is_div;
    start_any = start_mul || start_div;
    cnt_load  = start_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
    commit    = busy && (cnt == '0);
    stall_req = busy || ((is_mul || is_div) && !flush);

    state_next = state;
    if (start_mul) state_next = S_MULT;
`ifdef MD_DIV_EN
    if (start_div) state_next = S_DIV;
`endif
    if (commit) state_next = S_IDLE;
  end

  // Sign-extend to 64 bits so a single multiplier serves both mult and multu.
  always_comb begin
    ext_a   = {{32{sgn_q & a_q[31]}}, a_q};
    ext_b   = {{32{sgn_q & b_q[31]}}, b_q};
    product = ext_a * ext_b;
  end

`ifdef MD_DIV_EN
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000, 0.
  always_comb begin
    a_neg    = sgn_q & a_q[31];
    b_neg    = sgn_q & b_q[31];
    div_zero = (b_q == '0);
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    if (div_zero) b_mag = 32'd1;
    q_mag    = a_mag / b_mag;
    r_mag    = a_mag % b_mag;
  end
`endif

  always_comb begin
    res_hi = product[63:32];
    res_lo = product[31:0];
    res_ok = 1'b1;
`ifdef MD_DIV_EN
    if (state == S_DIV) begin
      res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      res_hi = a_neg ? -r_mag : r_mag;
      res_ok = !div_zero;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (start_any) begin
        cnt   <= cnt_load;
        a_q   <= md_a;
        b_q   <= md_b;
        sgn_q <= (md_op == 3'd1) || (md_op == 3'd3);
      end else if (busy && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && res_ok) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (state == S_IDLE && !flush) begin
        if (md_op == 3'd5) hi <= md_a;
        if (md_op == 3'd6) lo <= md_a;
      end
    end
  end

endmodule
